// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter between two requesters and a single-port 4096x32 RAM.
// Sequences registered RAM reads, read-modify-write sub-word stores and sub-word load extraction.
module ram_access_arbiter #(
   parameter int ADDR_W      = 12,
   parameter bit FIRST_GRANT = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [1:0]        a_size,
   input  logic              a_uns,
   input  logic [ADDR_W+1:0] a_addr,
   input  logic [31:0]       a_wdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [1:0]        b_size,
   input  logic              b_uns,
   input  logic [ADDR_W+1:0] b_addr,
   input  logic [31:0]       b_wdata,
   output logic              a_ack,
   output logic              b_ack,
   output logic [31:0]       rdata,
   output logic              err,
   output logic [ADDR_W-1:0] ram_address,
   output logic [31:0]       ram_data_input,
   output logic              ram_store,
   output logic              ram_load,
   input  logic [31:0]       ram_data_output
);

   typedef enum logic [2:0] {IDLE, ACC, WAIT, WR, RESP} state_t;

   state_t            state_q, state_d;
   logic              port_q, port_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;

   // Contended requests go to the port that did not win last time.
   logic              gnt;
   logic              sel_we, sel_uns, sel_bad;
   logic [1:0]        sel_size;
   logic [ADDR_W+1:0] sel_addr;
   logic [31:0]       sel_wdata;

   assign gnt       = (a_req && b_req) ? ~last_q : b_req;
   assign sel_we    = gnt ? b_we    : a_we;
   assign sel_uns   = gnt ? b_uns   : a_uns;
   assign sel_size  = gnt ? b_size  : a_size;
   assign sel_addr  = gnt ? b_addr  : a_addr;
   assign sel_wdata = gnt ? b_wdata : a_wdata;
   assign sel_bad   = (sel_size == 2'b11) ||
                      (sel_size == 2'b01 && sel_addr[0]) ||
                      (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_val;
   logic [31:0] merged;

   always_comb begin
      byte_lane = ram_data_output[{addr_q[1:0], 3'b000} +: 8];
      half_lane = ram_data_output[{addr_q[1], 4'b0000} +: 16];
      case (size_q)
         2'b00:   load_val = {{24{~uns_q & byte_lane[7]}}, byte_lane};
         2'b01:   load_val = {{16{~uns_q & half_lane[15]}}, half_lane};
         default: load_val = ram_data_output;
      endcase
      merged = ram_data_output;
      if (size_q == 2'b00)
         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else if (size_q == 2'b01)
         merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   // The merged RMW word reuses wdata_q, so the RAM write data is always wdata_q.
   assign ram_address    = addr_q[ADDR_W+1:2];
   assign ram_data_input = wdata_q;
   assign rdata          = rdata_q;

   always_comb begin
      state_d   = state_q;
      port_d    = port_q;
      last_d    = last_q;
      we_d      = we_q;
      size_d    = size_q;
      uns_d     = uns_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      ram_store = 1'b0;
      ram_load  = 1'b0;
      a_ack     = 1'b0;
      b_ack     = 1'b0;
      err       = 1'b0;
      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               port_d  = gnt;
               last_d  = gnt;
               we_d    = sel_we;
               size_d  = sel_size;
               uns_d   = sel_uns;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               err_d   = sel_bad;
               state_d = sel_bad ? RESP : ACC;
            end
         end
         ACC: begin
            if (we_q && size_q == 2'b10) begin
               ram_store = 1'b1;
               state_d   = RESP;
            end else begin
               ram_load = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (we_q) begin
               wdata_d = merged;
               state_d = WR;
            end else begin
               rdata_d = load_val;
               state_d = RESP;
            end
         end
         WR: begin
            ram_store = 1'b1;
            state_d   = RESP;
         end
         RESP: begin
            a_ack   = ~port_q;
            b_ack   = port_q;
            err     = err_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         port_q  <= 1'b0;
         last_q  <= ~FIRST_GRANT;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         port_q  <= port_d;
         last_q  <= last_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

endmodule
